// File: rtl/uart_loader.sv
// -----------------------------------------------------------------------------
// uart_loader
//
// Boot loader that sits between the UART receiver and the ramio request port.
// It receives a little-endian image of the form
//   word count N (4 bytes), N data words (4 bytes each), checksum (4 bytes)
// and writes each data word to RAM at BaseAddress + 4*index. The checksum is
// the sum of all data words modulo 2^32. When the checksum matches, done goes
// high (sticky) and the CPU may be released. A count above MaxWordCount or a
// checksum mismatch raises error (sticky). Until done is high the loader is
// the only master of the ramio port.
//
// Parameters
//   MaxWordCount  largest accepted image, in 32-bit words (<= 65535)
//   BaseAddress   byte address of the first word, 4-byte aligned
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   rx_data        received byte, valid while rx_data_ready is high
//   rx_data_ready  a byte is pending in the receiver (level)
//   rx_data_read   one-cycle acknowledge of the pending byte
//   enable         ramio request strobe (one cycle per word)
//   write_type     2'b11 during a request, else 2'b00
//   read_type      always 3'b000
//   address        ramio byte address
//   data_in        ramio write data
//   busy           ramio busy
//   done           image loaded and checksum matched (sticky)
//   error          size or checksum failure (sticky)
//   words_written  number of completed word writes
// -----------------------------------------------------------------------------

// Invariants on the request port and status flags.
module uart_loader_checker (
  input logic       clk,
  input logic       rst_n,
  input logic       enable,
  input logic [1:0] write_type,
  input logic [2:0] read_type,
  input logic       rx_data_read,
  input logic       done,
  input logic       error
);

  // done and error are mutually exclusive.
  a_flags_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(done && error));

  // A request always carries the word write type.
  a_enable_type: assert property (@(posedge clk) disable iff (!rst_n)
    enable |-> (write_type == 2'b11));

  // Requests are single-cycle pulses.
  a_enable_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    enable |=> !enable);

  // Acknowledges are single-cycle pulses.
  a_ack_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    rx_data_read |=> !rx_data_read);

  // The loader never reads.
  a_no_read: assert property (@(posedge clk) disable iff (!rst_n)
    read_type == 3'b000);

endmodule

module uart_loader #(
  parameter int unsigned MaxWordCount = 4096,
  parameter logic [31:0] BaseAddress  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_ready,
  output logic        rx_data_read,
  output logic        enable,
  output logic [1:0]  write_type,
  output logic [2:0]  read_type,
  output logic [31:0] address,
  output logic [31:0] data_in,
  input  logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  localparam logic [31:0] MAX_WORDS = 32'(MaxWordCount);

  typedef enum logic [2:0] {
    RX_COUNT = 3'd0,
    RX_WORD  = 3'd1,
    WR_ISSUE = 3'd2,
    WR_WAIT  = 3'd3,
    RX_SUM   = 3'd4,
    DONE     = 3'd5,
    ERROR    = 3'd6
  } state_t;

  state_t      state_r,      state_s;
  logic [1:0]  byte_cnt_r,   byte_cnt_s;
  logic [31:0] asm_r,        asm_s;
  logic [31:0] sum_r,        sum_s;
  logic [15:0] count_r,      count_s;
  logic [15:0] words_r,      words_s;
  logic        enable_r,     enable_s;
  logic [1:0]  write_type_r, write_type_s;
  logic [31:0] address_r,    address_s;
  logic [31:0] data_r,       data_s;
  logic        rx_read_r,    rx_read_s;
  logic        done_r,       done_s;
  logic        error_r,      error_s;

  logic        rx_state_s;
  logic        take_byte_s;
  logic        word_done_s;
  logic [31:0] word_s;
  logic [15:0] words_inc_s;

  // A byte is accepted only in a receive state, and never in the cycle the
  // previous byte is being acknowledged (the receiver still shows it then).
  assign rx_state_s  = (state_r == RX_COUNT) || (state_r == RX_WORD) ||
                       (state_r == RX_SUM);
  assign take_byte_s = rx_state_s && rx_data_ready && !rx_read_r;
  assign word_done_s = take_byte_s && (byte_cnt_r == 2'd3);
  // Complete field as it stands once the current (fourth) byte lands.
  assign word_s      = {rx_data, asm_r[23:0]};
  assign words_inc_s = words_r + 16'd1;

  // Next-state and next-output logic for the load sequencer.
  always_comb begin
    state_s      = state_r;
    byte_cnt_s   = byte_cnt_r;
    asm_s        = asm_r;
    sum_s        = sum_r;
    count_s      = count_r;
    words_s      = words_r;
    enable_s     = 1'b0;
    write_type_s = 2'b00;
    address_s    = address_r;
    data_s       = data_r;
    rx_read_s    = 1'b0;
    done_s       = done_r;
    error_s      = error_r;

    if (take_byte_s) begin
      rx_read_s  = 1'b1;
      byte_cnt_s = byte_cnt_r + 2'd1;
      case (byte_cnt_r)
        2'd0:    asm_s[7:0]   = rx_data;
        2'd1:    asm_s[15:8]  = rx_data;
        2'd2:    asm_s[23:16] = rx_data;
        default: asm_s[31:24] = rx_data;
      endcase
    end else begin
      rx_read_s = 1'b0;
    end

    case (state_r)
      RX_COUNT: begin
        if (word_done_s) begin
          if (word_s > MAX_WORDS) begin
            state_s = ERROR;
            error_s = 1'b1;
          end else if (word_s == 32'd0) begin
            state_s = RX_SUM;
          end else begin
            // Fits in 16 bits because MaxWordCount <= 65535.
            count_s = word_s[15:0];
            state_s = RX_WORD;
          end
        end else begin
          state_s = RX_COUNT;
        end
      end

      RX_WORD: begin
        if (word_done_s) begin
          // Request fields are loaded here so enable is a registered pulse
          // that is high exactly during WR_ISSUE.
          sum_s        = sum_r + word_s;
          data_s       = word_s;
          address_s    = BaseAddress + {14'd0, words_r, 2'b00};
          enable_s     = 1'b1;
          write_type_s = 2'b11;
          state_s      = WR_ISSUE;
        end else begin
          state_s = RX_WORD;
        end
      end

      WR_ISSUE: begin
        state_s = WR_WAIT;
      end

      WR_WAIT: begin
        if (!busy) begin
          words_s = words_inc_s;
          if (words_inc_s == count_r) begin
            state_s = RX_SUM;
          end else begin
            state_s = RX_WORD;
          end
        end else begin
          state_s = WR_WAIT;
        end
      end

      RX_SUM: begin
        if (word_done_s) begin
          if (word_s == sum_r) begin
            state_s = DONE;
            done_s  = 1'b1;
          end else begin
            state_s = ERROR;
            error_s = 1'b1;
          end
        end else begin
          state_s = RX_SUM;
        end
      end

      DONE: begin
        state_s = DONE;
      end

      ERROR: begin
        state_s = ERROR;
      end

      default: begin
        // Unreachable encoding: park in the failure state with a clean flag pair.
        state_s = ERROR;
        done_s  = 1'b0;
        error_s = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= RX_COUNT;
      byte_cnt_r   <= 2'd0;
      asm_r        <= 32'd0;
      sum_r        <= 32'd0;
      count_r      <= 16'd0;
      words_r      <= 16'd0;
      enable_r     <= 1'b0;
      write_type_r <= 2'b00;
      address_r    <= 32'd0;
      data_r       <= 32'd0;
      rx_read_r    <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      byte_cnt_r   <= byte_cnt_s;
      asm_r        <= asm_s;
      sum_r        <= sum_s;
      count_r      <= count_s;
      words_r      <= words_s;
      enable_r     <= enable_s;
      write_type_r <= write_type_s;
      address_r    <= address_s;
      data_r       <= data_s;
      rx_read_r    <= rx_read_s;
      done_r       <= done_s;
      error_r      <= error_s;
    end
  end

  assign rx_data_read  = rx_read_r;
  assign enable        = enable_r;
  assign write_type    = write_type_r;
  assign read_type     = 3'b000;
  assign address       = address_r;
  assign data_in       = data_r;
  assign done          = done_r;
  assign error         = error_r;
  assign words_written = words_r;

  uart_loader_checker u_checker (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable_r),
    .write_type   (write_type_r),
    .read_type    (read_type),
    .rx_data_read (rx_read_r),
    .done         (done_r),
    .error        (error_r)
  );

endmodule

// File: tb/tb_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_loader
//
// Table-driven bench for uart_loader. Each record describes an image (count,
// data words, checksum, trailing bytes, ramio busy length) and the expected
// outcome. A negedge process models the UART receiver (level ready, cleared on
// acknowledge) and ramio busy, and logs every write request.
// -----------------------------------------------------------------------------
module tb_uart_loader;

  localparam int          MAX  = 3;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_data_ready;
  logic        rx_data_read;
  logic        enable;
  logic [1:0]  write_type;
  logic [2:0]  read_type;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  uart_loader #(.MaxWordCount(MAX), .BaseAddress(BASE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .rx_data_read  (rx_data_read),
    .enable        (enable),
    .write_type    (write_type),
    .read_type     (read_type),
    .address       (address),
    .data_in       (data_in),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Receiver / ramio model state
  logic [7:0]  rxq[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [1:0]  wr_type_q[$];
  int          busy_len = 0;
  int          bc = 0;
  int          ack_cnt = 0;
  int          overlap_cnt = 0;
  int          read_busy_cnt = 0;
  logic        enable_prev = 1'b0;

  typedef struct {
    logic [31:0] count;
    logic [95:0] words;      // word i in bits [32i+31:32i]
    int          nsend;      // data words actually sent
    logic [31:0] sum;
    bit          send_sum;
    int          extra;      // trailing 0xAA bytes
    int          blen;       // busy length after each request
    bit          exp_done;
    bit          exp_error;
    int          exp_writes;
    int          exp_acks;
    int          exp_left;   // bytes still queued in the receiver at the end
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic [31:0] count, input logic [95:0] words,
                              input int nsend, input logic [31:0] sum, input bit send_sum,
                              input int extra, input int blen, input bit exp_done,
                              input bit exp_error, input int exp_writes,
                              input int exp_acks, input int exp_left);
    vec_t v;
    v.count = count; v.words = words; v.nsend = nsend; v.sum = sum;
    v.send_sum = send_sum; v.extra = extra; v.blen = blen;
    v.exp_done = exp_done; v.exp_error = exp_error; v.exp_writes = exp_writes;
    v.exp_acks = exp_acks; v.exp_left = exp_left;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver, ramio busy and request monitor, all evaluated mid-cycle.
  always @(negedge clk) begin
    if (enable) begin
      if (enable_prev || busy) overlap_cnt++;
      wr_addr_q.push_back(address);
      wr_data_q.push_back(data_in);
      wr_type_q.push_back(write_type);
    end
    if (rx_data_read && busy && !enable) read_busy_cnt++;
    enable_prev = enable;

    if (enable) bc = busy_len;
    else if (bc > 0) bc = bc - 1;
    busy = (bc > 0);

    if (rx_data_read) begin
      ack_cnt++;
      if (rxq.size() > 0) void'(rxq.pop_front());
    end
    if (rxq.size() > 0) begin
      rx_data_ready = 1'b1;
      rx_data       = rxq[0];
    end else begin
      rx_data_ready = 1'b0;
      rx_data       = 8'h00;
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) rxq.push_back(w[8*k +: 8]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_enable"}, {31'd0, enable}, 32'd0);
    check32({tag, "_wtype"}, {30'd0, write_type}, 32'd0);
    check32({tag, "_rtype"}, {29'd0, read_type}, 32'd0);
    check32({tag, "_addr"}, address, 32'd0);
    check32({tag, "_data"}, data_in, 32'd0);
    check32({tag, "_ack"}, {31'd0, rx_data_read}, 32'd0);
    check32({tag, "_done"}, {31'd0, done}, 32'd0);
    check32({tag, "_error"}, {31'd0, error}, 32'd0);
    check32({tag, "_words"}, {16'd0, words_written}, 32'd0);
  endtask

  task automatic clear_model();
    ack_cnt = 0; overlap_cnt = 0; read_busy_cnt = 0;
    wr_addr_q.delete(); wr_data_q.delete(); wr_type_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rxq.delete();
    bc = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int i, input bit do_reset);
    int  n;
    bit  flagged;
    if (do_reset) apply_reset();
    clear_model();
    busy_len = vecs[i].blen;
    push_word(vecs[i].count);
    for (int k = 0; k < vecs[i].nsend; k++) push_word(vecs[i].words[32*k +: 32]);
    if (vecs[i].send_sum) push_word(vecs[i].sum);
    for (int k = 0; k < vecs[i].extra; k++) rxq.push_back(8'hAA);

    n = 0;
    flagged = 1'b0;
    while (n < 3000) begin
      @(negedge clk);
      if (done || error) begin
        flagged = 1'b1;
        break;
      end
      n++;
    end
    check32($sformatf("v%0d_flag_seen", i), {31'd0, flagged}, 32'd1);
    // The flag rises on the edge that captures the final byte, so that byte's
    // acknowledge is visible in the same cycle.
    if (flagged) check32($sformatf("v%0d_flag_with_ack", i), {31'd0, rx_data_read}, 32'd1);

    repeat (20) @(negedge clk);
    check32($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
    check32($sformatf("v%0d_error", i), {31'd0, error}, {31'd0, vecs[i].exp_error});
    check32($sformatf("v%0d_words", i), {16'd0, words_written}, 32'(vecs[i].exp_writes));
    check32($sformatf("v%0d_nwrites", i), 32'(wr_addr_q.size()), 32'(vecs[i].exp_writes));
    for (int k = 0; k < vecs[i].exp_writes; k++) begin
      if (k < wr_addr_q.size()) begin
        check32($sformatf("v%0d_w%0d_addr", i, k), wr_addr_q[k], BASE + 32'(4 * k));
        check32($sformatf("v%0d_w%0d_data", i, k), wr_data_q[k], vecs[i].words[32*k +: 32]);
        check32($sformatf("v%0d_w%0d_type", i, k), {30'd0, wr_type_q[k]}, 32'd3);
      end
    end
    check32($sformatf("v%0d_acks", i), 32'(ack_cnt), 32'(vecs[i].exp_acks));
    check32($sformatf("v%0d_left", i), 32'(rxq.size()), 32'(vecs[i].exp_left));
    check32($sformatf("v%0d_overlap", i), 32'(overlap_cnt), 32'd0);
    check32($sformatf("v%0d_ack_in_busy", i), 32'(read_busy_cnt), 32'd0);
    check32($sformatf("v%0d_rtype", i), {29'd0, read_type}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rx_data = 8'h00; rx_data_ready = 1'b0; busy = 1'b0;

    //            count   words (w2,w1,w0)                                   nsend sum            ssum extra blen done err wr acks left
    vecs[0] = mk(32'd2, {32'h0, 32'h1234_5678, 32'hD5B8_A9C4},              2, 32'hE7ED_003C, 1'b1, 0, 0, 1'b1, 1'b0, 2, 16, 0);
    vecs[1] = mk(32'd2, {32'h0, 32'h1234_5678, 32'hD5B8_A9C4},              2, 32'h0000_0000, 1'b1, 0, 0, 1'b0, 1'b1, 2, 16, 0);
    vecs[2] = mk(32'd0, 96'd0,                                              0, 32'h0000_0000, 1'b1, 0, 0, 1'b1, 1'b0, 0, 8,  0);
    vecs[3] = mk(32'd4, 96'd0,                                              0, 32'h0000_0000, 1'b0, 4, 0, 1'b0, 1'b1, 0, 4,  4);
    vecs[4] = mk(32'd2, {32'h0, 32'h1234_5678, 32'hD5B8_A9C4},              2, 32'hE7ED_003C, 1'b1, 0, 5, 1'b1, 1'b0, 2, 16, 0);
    vecs[5] = mk(32'd3, {32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF},      3, 32'h8000_0001, 1'b1, 0, 1, 1'b1, 1'b0, 3, 20, 0);
    vecs[6] = mk(32'd0, 96'd0,                                              0, 32'h0000_0001, 1'b1, 0, 0, 1'b0, 1'b1, 0, 8,  0);

    for (int i = 0; i < 7; i++) run_vec(i, 1'b1);

    // Reset in the middle of the second data word, after one write completed.
    apply_reset();
    clear_model();
    busy_len = 0;
    push_word(32'd2);
    push_word(32'hD5B8_A9C4);
    rxq.push_back(8'h78);
    rxq.push_back(8'h56);
    n = 0;
    while ((ack_cnt < 10) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    check32("mid_acks", 32'(ack_cnt), 32'd10);
    repeat (3) @(negedge clk);
    check32("mid_words", {16'd0, words_written}, 32'd1);
    check32("mid_addr", address, BASE);
    check32("mid_data", data_in, 32'hD5B8_A9C4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("mid_rst");
    run_vec(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
